seven_segment_mux_driver: RTL and testbench
===========================================

Name: seven_segment_mux_driver

Overview:
- Parametrised N-digit multiplexed 7-segment display driver. Time-multiplexes hex nybbles onto shared segment lines, one digit at a time.
- Adds features beyond the fixed 4-digit driver: per-digit decimal points, per-digit enables, PWM brightness, inter-digit blanking (anti-ghosting), leading-zero blanking, configurable pin polarity, tear-free frame snapshot and a frame strobe.
- Sits between top-level counters/data registers and the board pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..16).
- SLOT_LOG2, 10, each digit slot lasts 2^SLOT_LOG2 clocks.
- BRIGHTNESS_BITS, 4, width of brightness input (1..SLOT_LOG2).
- DEAD_CYCLES, 8, clocks at slot start with all anodes off (< 2^SLOT_LOG2).
- ANODE_ACTIVE_HIGH, 1, 1: anode driven 1 = digit on; 0: inverted.
- SEGMENT_ACTIVE_LOW, 1, 1: cathode/dp driven 0 = segment lit; 0: inverted.

Ports:
- clock  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- data  in  4*NUM_DIGITS  hex nybbles; digit i = data[4i+3:4i]; digit 0 is least significant.
- dp  in  NUM_DIGITS  decimal point request per digit.
- digit_enable  in  NUM_DIGITS  0 blanks that digit entirely.
- brightness  in  BRIGHTNESS_BITS  duty code; 0 = display off.
- blank_leading_zeros  in  1  suppress leading zero digits.
- cathode  out  7  segments a..g on bits 0..6, polarity per SEGMENT_ACTIVE_LOW.
- dp_out  out  1  decimal point segment.
- anode  out  NUM_DIGITS  digit selects, polarity per ANODE_ACTIVE_HIGH.
- frame_strobe  out  1  one-clock pulse at start of each frame.

Behaviour:
- Counters: phase p (SLOT_LOG2 bits) increments every clock. digit index d (clog2(NUM_DIGITS) bits, min 1) increments when p wraps; d wraps from NUM_DIGITS-1 to 0. Non-power-of-2 NUM_DIGITS has no skipped slots.
- Snapshot: when d==0 and p==0, register data, dp, digit_enable, brightness and blank_leading_zeros. All display decisions in the frame use the snapshot. Input changes mid-frame are invisible until the next frame.
- frame_strobe: high for exactly the one clock on which the snapshot is taken.
- Blank mask, computed from the snapshot: digit i is zero-blanked iff blank_leading_zeros=1, i>0, and nybbles i..NUM_DIGITS-1 are all 0. Digit 0 is never zero-blanked, so all-zero data shows a single "0". dp is still shown on a zero-blanked digit.
- Anode for digit d is active iff all of the following hold:
  - p >= DEAD_CYCLES;
  - p[SLOT_LOG2-1 -: BRIGHTNESS_BITS] < brightness_snap;
  - digit_enable_snap[d]=1;
  - d is not zero-blanked, or dp_snap[d]=1.
- All other anodes are inactive. Never more than one anode is active.
- Cathode encoding (lit segments):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc;
  - 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
- A zero-blanked digit lights no a..g segments. dp_out is lit iff dp_snap[d].
- Cathode and dp_out change only when p==0, i.e. inside the dead time, so segments never change while an anode is on.
- Outputs are registered: the pin state reflects (d, p) of the previous clock, a fixed 1-clock latency.
- Brightness at maximum (2^B-1) gives duty (2^B-1)/2^B minus dead time. Brightness is sampled only at frame start.
- Reset: p=0, d=0, snapshot cleared to zero. All anodes inactive, all cathodes and dp_out unlit, frame_strobe=0.
- Reset mid-slot: anodes go inactive on the next clock. On the first clock after reset deasserts, frame_strobe fires and the snapshot is taken.

Decomposition:
- Package seven_segment_pkg holds:
  - the segment-index constants a..g = 0..6;
  - the 16-entry hex-to-segment table as a localparam array, active-high lit encoding;
  - a function returning the counter width clog2(max(NUM_DIGITS,2)).
- Sub-module hex_to_seven_segment: combinational, 4-bit nybble in, 7-bit active-high segments out. Polarity inversion is applied in the parent.

Test Plan:
- Reset and scan order. NUM_DIGITS=4, SLOT_LOG2=4, DEAD_CYCLES=2, BRIGHTNESS_BITS=2, brightness=3, data=16'h1234, all enabled, active-high polarities for readability.
  - Anode sequence 0001,0010,0100,1000 repeating, each on for clocks 2..11 of its 16-clock slot.
  - Cathode equals the encoding of 4,3,2,1 respectively.
  - frame_strobe every 64 clocks.
  - During reset: anode=0, cathode=0.
- Snapshot. Change data to 16'hABCD when d=2 → digits 2 and 3 still show 2 and 1. The next frame shows D,C,B,A.
- Brightness. brightness=1 → anode on clocks 2..3 of each slot only. brightness=0 → anode stays 0 for a whole frame.
- Leading zeros. data=16'h0050, blank_leading_zeros=1 → digits 3 and 2 show no anode. data=16'h0000 → only digit 0 shows "0". dp=4'b1000 → digit 3 anode active with only dp_out lit.
- Polarity and enable. ANODE_ACTIVE_HIGH=0, SEGMENT_ACTIVE_LOW=1, digit_enable=4'b1011 → digit 2 anode stays 1. Showing 8 drives cathode=7'b0000000.
- Reset mid-operation. Assert reset at d=2, p=7 → on the next clock anode is inactive and cathode is unlit. After release, frame_strobe pulses on the first clock and scanning resumes at d=0.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment indices,
// the hex glyph table and the digit-counter width helper.
package seven_segment_pkg;

   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;
   localparam int unsigned SEG_COUNT = 7;

   // Lit-segment glyphs for 0..F, bit SEG_A..SEG_G set = segment on.
   localparam logic [SEG_COUNT-1:0] HEX_TO_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int unsigned digit_cnt_width(input int unsigned num_digits);
      return (num_digits < 2) ? 1 : $clog2(num_digits);
   endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nybble to active-high lit-segment decoder.
module hex_to_seven_segment
   import seven_segment_pkg::*;
(
   input  logic [3:0]           nybble,
   output logic [SEG_COUNT-1:0] segments_c
);

   assign segments_c = HEX_TO_SEG[nybble];

endmodule

// File: rtl/seven_segment_mux_driver.sv
// N-digit time-multiplexed seven-segment driver with per-frame input snapshot,
// PWM brightness, dead-time blanking, leading-zero suppression and pin polarity.
module seven_segment_mux_driver
   import seven_segment_pkg::*;
#(
   parameter int unsigned NUM_DIGITS         = 4,
   parameter int unsigned SLOT_LOG2          = 10,
   parameter int unsigned BRIGHTNESS_BITS    = 4,
   parameter int unsigned DEAD_CYCLES        = 8,
   parameter bit          ANODE_ACTIVE_HIGH  = 1'b1,
   parameter bit          SEGMENT_ACTIVE_LOW = 1'b1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [4*NUM_DIGITS-1:0]    data,
   input  logic [NUM_DIGITS-1:0]      dp,
   input  logic [NUM_DIGITS-1:0]      digit_enable,
   input  logic [BRIGHTNESS_BITS-1:0] brightness,
   input  logic                       blank_leading_zeros,
   output logic [SEG_COUNT-1:0]       cathode,
   output logic                       dp_out,
   output logic [NUM_DIGITS-1:0]      anode,
   output logic                       frame_strobe
);

   localparam int unsigned DW     = digit_cnt_width(NUM_DIGITS);
   localparam int unsigned DATA_W = 4 * NUM_DIGITS;
   localparam logic        ANODE_INV = ~ANODE_ACTIVE_HIGH;
   localparam logic        SEG_INV   = SEGMENT_ACTIVE_LOW;

   logic [SLOT_LOG2-1:0]       phase;
   logic [DW-1:0]              digit;

   logic [DATA_W-1:0]          data_snap;
   logic [NUM_DIGITS-1:0]      dp_snap;
   logic [NUM_DIGITS-1:0]      enable_snap;
   logic [BRIGHTNESS_BITS-1:0] bright_snap;
   logic                       blz_snap;

   logic                       take_c;
   logic [DATA_W-1:0]          data_e_c;
   logic [NUM_DIGITS-1:0]      dp_e_c;
   logic [NUM_DIGITS-1:0]      enable_e_c;
   logic [BRIGHTNESS_BITS-1:0] bright_e_c;
   logic                       blz_e_c;

   logic [NUM_DIGITS-1:0]      zblank_c;
   logic [3:0]                 nybble_c;
   logic                       en_sel_c;
   logic                       dp_sel_c;
   logic                       zb_sel_c;
   logic                       on_c;
   logic [NUM_DIGITS-1:0]      anode_onehot_c;
   logic [SEG_COUNT-1:0]       seg_raw_c;

   // Slot phase and digit scan counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase <= '0;
         digit <= '0;
      end else begin
         phase <= phase + SLOT_LOG2'(1);
         if (phase == '1) begin
            digit <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + DW'(1);
         end
      end
   end

   assign take_c = (digit == '0) && (phase == '0);

   // The frame-start clock already decides with the values being captured.
   assign data_e_c   = take_c ? data                : data_snap;
   assign dp_e_c     = take_c ? dp                  : dp_snap;
   assign enable_e_c = take_c ? digit_enable        : enable_snap;
   assign bright_e_c = take_c ? brightness          : bright_snap;
   assign blz_e_c    = take_c ? blank_leading_zeros : blz_snap;

   always_ff @(posedge clock) begin
      if (reset) begin
         data_snap   <= '0;
         dp_snap     <= '0;
         enable_snap <= '0;
         bright_snap <= '0;
         blz_snap    <= 1'b0;
      end else if (take_c) begin
         data_snap   <= data;
         dp_snap     <= dp;
         enable_snap <= digit_enable;
         bright_snap <= brightness;
         blz_snap    <= blank_leading_zeros;
      end
   end

   // Leading-zero mask: a digit blanks while every nybble from it upward is zero.
   always_comb begin
      logic zero_run;
      zblank_c = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run    = zero_run && (data_e_c[4*i +: 4] == 4'h0);
         zblank_c[i] = blz_e_c && (i != 0) && zero_run;
      end
   end

   always_comb begin
      nybble_c = '0;
      en_sel_c = 1'b0;
      dp_sel_c = 1'b0;
      zb_sel_c = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit == DW'(i)) begin
            nybble_c = data_e_c[4*i +: 4];
            en_sel_c = enable_e_c[i];
            dp_sel_c = dp_e_c[i];
            zb_sel_c = zblank_c[i];
         end
      end
   end

   hex_to_seven_segment u_hex (
      .nybble     (nybble_c),
      .segments_c (seg_raw_c)
   );

   assign on_c = (phase >= SLOT_LOG2'(DEAD_CYCLES))
              && (phase[SLOT_LOG2-1 -: BRIGHTNESS_BITS] < bright_e_c)
              && en_sel_c
              && (!zb_sel_c || dp_sel_c);

   always_comb begin
      anode_onehot_c = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         anode_onehot_c[i] = on_c && (digit == DW'(i));
      end
   end

   // Pin registers; segments only move at phase 0, inside the dead time.
   always_ff @(posedge clock) begin
      if (reset) begin
         anode        <= {NUM_DIGITS{ANODE_INV}};
         cathode      <= {SEG_COUNT{SEG_INV}};
         dp_out       <= SEG_INV;
         frame_strobe <= 1'b0;
      end else begin
         anode        <= anode_onehot_c ^ {NUM_DIGITS{ANODE_INV}};
         frame_strobe <= take_c;
         if (phase == '0) begin
            cathode <= (zb_sel_c ? '0 : seg_raw_c) ^ {SEG_COUNT{SEG_INV}};
            dp_out  <= dp_sel_c ^ SEG_INV;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Scoreboard bench: two polarity variants of the driver checked every clock
// against a frame/slot arithmetic model of the display.
module tb_seven_segment_mux_driver;

   localparam int ND = 4;
   localparam int SL = 4;
   localparam int DC = 2;
   localparam int BB = 2;
   localparam int SLOT = 1 << SL;
   localparam int FRAME = SLOT * ND;

   typedef struct packed {
      logic [6:0] cat_hi;
      logic       dp_hi;
      logic [3:0] an_hi;
      logic       fs;
      logic [6:0] cat_lo;
      logic       dp_lo;
      logic [3:0] an_lo;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] data;
   logic [3:0]  dp;
   logic [3:0]  digit_enable;
   logic [1:0]  brightness;
   logic        blank_leading_zeros;

   logic [6:0]  cathode_hi, cathode_lo;
   logic        dp_out_hi, dp_out_lo;
   logic [3:0]  anode_hi, anode_lo;
   logic        frame_strobe_hi, frame_strobe_lo;

   int vectors = 0;
   int miscompares = 0;
   exp_t q[$];

   // Model state: clocks since reset release plus the frame snapshot.
   int          t = 0;
   logic [15:0] m_data;
   logic [3:0]  m_dp, m_en;
   int          m_bright;
   logic        m_blz;

   string seg_names[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   always #5 clock = ~clock;

   seven_segment_mux_driver #(
      .NUM_DIGITS(ND), .SLOT_LOG2(SL), .BRIGHTNESS_BITS(BB), .DEAD_CYCLES(DC),
      .ANODE_ACTIVE_HIGH(1'b1), .SEGMENT_ACTIVE_LOW(1'b0)
   ) dut_hi (
      .clock(clock), .reset(reset), .data(data), .dp(dp),
      .digit_enable(digit_enable), .brightness(brightness),
      .blank_leading_zeros(blank_leading_zeros),
      .cathode(cathode_hi), .dp_out(dp_out_hi), .anode(anode_hi),
      .frame_strobe(frame_strobe_hi)
   );

   seven_segment_mux_driver #(
      .NUM_DIGITS(ND), .SLOT_LOG2(SL), .BRIGHTNESS_BITS(BB), .DEAD_CYCLES(DC),
      .ANODE_ACTIVE_HIGH(1'b0), .SEGMENT_ACTIVE_LOW(1'b1)
   ) dut_lo (
      .clock(clock), .reset(reset), .data(data), .dp(dp),
      .digit_enable(digit_enable), .brightness(brightness),
      .blank_leading_zeros(blank_leading_zeros),
      .cathode(cathode_lo), .dp_out(dp_out_lo), .anode(anode_lo),
      .frame_strobe(frame_strobe_lo)
   );

   function automatic logic [6:0] seg_of(input int v);
      logic [6:0] r;
      string s;
      r = '0;
      s = seg_names[v];
      for (int k = 0; k < s.len(); k++) r[int'(s[k]) - 97] = 1'b1;
      return r;
   endfunction

   // Predict the pins after the coming clock edge, then queue it.
   task automatic step();
      exp_t       e;
      int         p, d, nyb;
      logic       zb, fs;
      logic [3:0] onehot;
      logic [6:0] segs;
      logic       dpl;
      onehot = '0;
      segs   = '0;
      dpl    = 1'b0;
      fs     = 1'b0;
      if (reset) begin
         t = 0;
      end else begin
         p = t % SLOT;
         d = (t / SLOT) % ND;
         fs = (t % FRAME) == 0;
         if (fs) begin
            m_data = data; m_dp = dp; m_en = digit_enable;
            m_bright = int'(brightness); m_blz = blank_leading_zeros;
         end
         nyb  = int'((m_data >> (4 * d)) & 16'hF);
         zb   = m_blz && (d > 0) && ((m_data >> (4 * d)) == 16'h0);
         segs = zb ? 7'h00 : seg_of(nyb);
         dpl  = m_dp[d];
         if (p >= DC && (p / (SLOT >> BB)) < m_bright && m_en[d] && (!zb || m_dp[d]))
            onehot = 4'(1 << d);
         t++;
      end
      e.an_hi = onehot;   e.cat_hi = segs;  e.dp_hi = dpl;
      e.an_lo = ~onehot;  e.cat_lo = ~segs; e.dp_lo = ~dpl;
      e.fs    = fs;
      @(posedge clock);
      q.push_back(e);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Advance until the next edge samples frame offset tt, bounded.
   task automatic run_until(input int tt);
      int guard;
      guard = 0;
      while ((t % FRAME) != tt && guard < 2 * FRAME) begin
         step();
         guard++;
      end
      if ((t % FRAME) != tt) begin
         vectors++;
         miscompares++;
         $display("FAIL sync: frame offset %0d, wanted %0d", t % FRAME, tt);
      end
   endtask

   // Monitor: every clock the DUT pins are a result to compare.
   always @(negedge clock) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         vectors++;
         if (anode_hi !== e.an_hi || cathode_hi !== e.cat_hi || dp_out_hi !== e.dp_hi ||
             frame_strobe_hi !== e.fs || anode_lo !== e.an_lo || cathode_lo !== e.cat_lo ||
             dp_out_lo !== e.dp_lo || frame_strobe_lo !== e.fs) begin
            miscompares++;
            $display("FAIL pins @%0t: hi an=%b cat=%b dp=%b fs=%b (want %b %b %b %b) lo an=%b cat=%b dp=%b fs=%b (want %b %b %b %b)",
                     $time, anode_hi, cathode_hi, dp_out_hi, frame_strobe_hi,
                     e.an_hi, e.cat_hi, e.dp_hi, e.fs,
                     anode_lo, cathode_lo, dp_out_lo, frame_strobe_lo,
                     e.an_lo, e.cat_lo, e.dp_lo, e.fs);
         end
      end
   end

   initial begin
      int k;
      reset = 1'b1;
      data = 16'h1234; dp = 4'b0000; digit_enable = 4'b1111;
      brightness = 2'd3; blank_leading_zeros = 1'b0;
      m_data = '0; m_dp = '0; m_en = '0; m_bright = 0; m_blz = 1'b0;
      #1;
      run(3);
      reset = 1'b0;
      run(2 * FRAME);

      // Mid-frame data change stays invisible until the next frame.
      run_until(2 * SLOT);
      data = 16'hABCD;
      run(2 * FRAME);

      brightness = 2'd1; run(FRAME + 8);
      brightness = 2'd0; run(FRAME + 8);
      brightness = 2'd3;

      blank_leading_zeros = 1'b1;
      data = 16'h0050; run(FRAME + 8);
      data = 16'h0000; run(FRAME + 8);
      dp = 4'b1000;    run(FRAME + 8);
      dp = 4'b0000; blank_leading_zeros = 1'b0;

      data = 16'h8888; digit_enable = 4'b1011; run(FRAME + 8);
      digit_enable = 4'b1111;

      // Reset landing on digit 2, phase 7.
      run_until(2 * SLOT + 7);
      reset = 1'b1; step();
      reset = 1'b0; run(FRAME + 8);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 4))
               0: begin
                  k = $urandom_range(0, 4);
                  data = 16'($urandom) >> (4 * k);
               end
               1: dp = 4'($urandom);
               2: digit_enable = 4'($urandom);
               3: brightness = 2'($urandom);
               default: blank_leading_zeros = 1'($urandom);
            endcase
         end
         reset = ($urandom_range(0, 999) == 0);
         step();
      end
      reset = 1'b0;
      run(4);

      #20;
      if (q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d expected results left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
